// File: rtl/tag_arb_node_pkg.sv
// Shared definitions for the tag tree: arbitration mode codes and the
// index-width helper used to size channel indices.
package tag_arb_node_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a channel index for a node with n inputs (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tag_arb_node_skid.sv
// Two-entry skid buffer with a registered head. Sustains one word per cycle
// when the consumer accepts continuously; a drain while full frees space
// only from the next cycle, so idata_rdy never depends on odata_rdy.
//
// Handshake: a word moves on the input side when idata_vld && idata_rdy,
// and on the output side when odata_vld && odata_rdy. A producer holds
// idata stable while idata_vld is high and idata_rdy is low.
module tag_skid #(
  parameter int DATA_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  idata_vld,
  output logic                  idata_rdy,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  odata_vld,
  input  logic                  odata_rdy
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_cnt;
  logic                  w_load;
  logic                  w_drain;

  assign idata_rdy = (r_cnt != 2'd2);
  assign odata_vld = (r_cnt != 2'd0);
  assign odata     = r_head;
  assign w_load    = idata_vld && idata_rdy;
  assign w_drain   = odata_vld && odata_rdy;

  // Occupancy and storage: head is always the oldest entry; tail only
  // holds a word while the buffer is full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_load) begin
            r_head <= idata;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (w_load && w_drain) begin
            r_head <= idata;
          end else if (w_load) begin
            r_tail <= idata;
            r_cnt  <= 2'd2;
          end else if (w_drain) begin
            r_cnt  <= 2'd0;
          end
        end
        default: begin
          if (w_drain) begin
            r_head <= r_tail;
            r_cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/tag_arb_node.sv
// N-to-1 tag arbitration node: fixed-priority or round-robin selection over
// N_IN upstream channels, with an optional registered skid-buffer output.
//
// Handshake: upstream channel i transfers when in_rdy[i] && in_ack[i] and
// holds in_rdy/in_tag until acked; downstream transfers when rdy && ack.
// in_ack is combinational from in_rdy, the round-robin pointer and buffer
// occupancy; in delay mode it never depends on ack in the same cycle.
module tag_arb_node
  import tag_arb_node_pkg::*;
#(
  parameter int  TAG_SZ       = 5,
  parameter int  N_IN         = 4,
  parameter int  MODE         = ARB_FIXED,
  parameter int  ENABLE_DELAY = 1,
  localparam int IDX_W        = idx_width(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*TAG_SZ-1:0] in_tag,
  input  logic [N_IN-1:0]        in_rdy,
  output logic [N_IN-1:0]        in_ack,
  output logic [TAG_SZ-1:0]      tag,
  output logic [IDX_W-1:0]       src,
  output logic                   rdy,
  input  logic                   ack
);

  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  w_sel_fix;
  logic [IDX_W-1:0]  w_sel_rr;
  logic [IDX_W-1:0]  w_sel;
  logic [TAG_SZ-1:0] w_tag_sel;
  logic [N_IN-1:0]   w_onehot;
  logic              w_any;
  logic              w_acc;
  logic              w_xfer;

  // Fixed priority: lowest ready index wins.
  always_comb begin
    w_sel_fix = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (in_rdy[i]) w_sel_fix = IDX_W'(i);
    end
  end

  // Round-robin: first ready channel at or after ptr+1, wrapping at N_IN.
  always_comb begin
    int idx;
    idx      = 0;
    w_sel_rr = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + 1 + k) % N_IN;
      if (in_rdy[idx]) w_sel_rr = IDX_W'(idx);
    end
  end

  assign w_sel     = (MODE == ARB_RR) ? w_sel_rr : w_sel_fix;
  assign w_any     = |in_rdy;
  assign w_xfer    = w_acc && w_any;
  assign w_tag_sel = in_tag[int'(w_sel)*TAG_SZ +: TAG_SZ];
  assign in_ack    = w_onehot;

  // One-hot grant, held at zero while reset is asserted.
  always_comb begin
    w_onehot = '0;
    if (w_xfer && rst) w_onehot[w_sel] = 1'b1;
  end

  // Last granted index; resets to N_IN-1 so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= IDX_W'(N_IN - 1);
    end else if (w_xfer) begin
      r_ptr <= w_sel;
    end
  end

  if (ENABLE_DELAY != 0) begin : g_delay
    logic [IDX_W+TAG_SZ-1:0] w_odata;
    logic                    w_irdy;

    tag_skid #(
      .DATA_WIDTH(IDX_W + TAG_SZ)
    ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .idata     ({w_sel, w_tag_sel}),
      .idata_vld (w_any),
      .idata_rdy (w_irdy),
      .odata     (w_odata),
      .odata_vld (rdy),
      .odata_rdy (ack)
    );

    assign w_acc = w_irdy;
    assign tag   = w_odata[TAG_SZ-1:0];
    assign src   = w_odata[IDX_W+TAG_SZ-1:TAG_SZ];
  end else begin : g_comb
    assign w_acc = ack;
    assign rdy   = w_any && rst;
    assign tag   = rst ? w_tag_sel : '0;
    assign src   = rst ? w_sel : '0;
  end

endmodule

// File: tb/tb_tag_arb_node.sv
// Bench for tag_arb_node: a fixed-priority and a round-robin 4-input node in
// delay mode share directed rdy/ack stimulus and are each compared every
// cycle against a queue-based reference; a 1-input combinational node is
// checked against the pass-through rules. Literal checks pin key sequences.
`timescale 1ns/1ps
module tb_tag_arb_node;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] in_rdy;
  logic       ack;
  int         cyc;

  logic [4:0] p1_in_tag;
  logic       p1_in_rdy;
  logic       p1_ack;
  logic       p1_in_ack;
  logic [4:0] p1_tag;
  logic       p1_src;
  logic       p1_rdy;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel that should win given mode, last grant and ready mask (-1: none).
  function automatic int pick(input int mode, input int ptr, input logic [3:0] r);
    int start;
    int i;
    start = (mode == 1) ? (ptr + 1) % 4 : 0;
    for (int k = 0; k < 4; k++) begin
      i = (start + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- DUTs + reference models ----------------
  for (genvar d = 0; d < 2; d++) begin : g_m
    logic [2:0]  seq [4];
    logic [19:0] w_in_tag;
    logic [3:0]  w_in_ack;
    logic [4:0]  w_tag;
    logic [1:0]  w_src;
    logic        w_rdy;
    logic [6:0]  mq [$];
    int          mptr;
    logic [3:0]  adv;

    initial begin
      for (int c = 0; c < 4; c++) seq[c] = 3'd1;
      adv  = '0;
      mptr = 3;
    end

    // Each channel presents {channel, sequence}; the sequence advances once acked.
    always_comb begin
      for (int c = 0; c < 4; c++) w_in_tag[c*5 +: 5] = {2'(c), seq[c]};
    end

    always @(posedge clk) begin
      #1;
      for (int c = 0; c < 4; c++) if (adv[c]) seq[c] = seq[c] + 3'd1;
    end

    tag_arb_node #(
      .TAG_SZ(5), .N_IN(4), .MODE(d), .ENABLE_DELAY(1)
    ) u_dut (
      .clk(clk), .rst(rst), .in_tag(w_in_tag), .in_rdy(in_rdy), .in_ack(w_in_ack),
      .tag(w_tag), .src(w_src), .rdy(w_rdy), .ack(ack)
    );

    // Compare against the reference, then advance it across the coming edge.
    always @(negedge clk) begin : p_cmp
      int         g;
      logic [3:0] e_ack;
      g = pick(d, mptr, in_rdy);
      if (!rst) begin
        mq.delete();
        mptr = 3;
        adv  = '0;
        chk($sformatf("m%0d_rst_in_ack", d), w_in_ack, 0);
        chk($sformatf("m%0d_rst_rdy", d), w_rdy, 0);
        chk($sformatf("m%0d_rst_tag", d), w_tag, 0);
        chk($sformatf("m%0d_rst_src", d), w_src, 0);
      end else begin
        e_ack = (mq.size() < 2 && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("m%0d_in_ack", d), w_in_ack, e_ack);
        chk($sformatf("m%0d_rdy", d), w_rdy, (mq.size() != 0));
        if (mq.size() != 0) begin
          chk($sformatf("m%0d_tag", d), w_tag, mq[0][4:0]);
          chk($sformatf("m%0d_src", d), w_src, mq[0][6:5]);
        end
        if (ack && mq.size() != 0) void'(mq.pop_front());
        if (e_ack != 4'b0000) begin
          mq.push_back({2'(g), w_in_tag[g*5 +: 5]});
          mptr = g;
        end
        adv = e_ack;
      end
    end
  end

  tag_arb_node #(
    .TAG_SZ(5), .N_IN(1), .MODE(0), .ENABLE_DELAY(0)
  ) u_p1 (
    .clk(clk), .rst(rst), .in_tag(p1_in_tag), .in_rdy(p1_in_rdy), .in_ack(p1_in_ack),
    .tag(p1_tag), .src(p1_src), .rdy(p1_rdy), .ack(p1_ack)
  );

  // Single-input combinational node is a pass-through.
  always @(negedge clk) begin
    chk("p1_src", p1_src, 0);
    if (rst) begin
      chk("p1_tag", p1_tag, p1_in_tag);
      chk("p1_rdy", p1_rdy, p1_in_rdy);
      chk("p1_in_ack", p1_in_ack, p1_ack & p1_in_rdy);
    end else begin
      chk("p1_rst_rdy", p1_rdy, 0);
      chk("p1_rst_in_ack", p1_in_ack, 0);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    p1_in_tag = 5'(cyc * 7);
    p1_in_rdy = (cyc % 3) != 0;
    p1_ack    = (cyc % 2) == 0;
  endtask

  logic [4:0] vec [12];
  logic [2:0] t0;

  initial begin
    vec = '{5'b1111_1, 5'b0110_0, 5'b0110_0, 5'b0110_1, 5'b1001_1, 5'b1101_0,
            5'b0000_1, 5'b0101_1, 5'b1010_1, 5'b1111_0, 5'b1111_1, 5'b0011_1};
    cyc = 0;
    rst = 1'b1;
    in_rdy = 4'b1111;
    ack = 1'b1;
    p1_in_tag = 5'd3;
    p1_in_rdy = 1'b1;
    p1_ack = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("lit_rst_rr_in_ack", g_m[1].w_in_ack, 0);
    chk("lit_rst_fp_in_ack", g_m[0].w_in_ack, 0);
    chk("lit_rst_rr_rdy", g_m[1].w_rdy, 0);
    chk("lit_rst_rr_tag", g_m[1].w_tag, 0);
    repeat (2) step();

    // Round-robin from reset: src 0,1,2,3,0 one per cycle after 1-cycle latency.
    rst = 1'b1;
    @(negedge clk);
    chk("lit_rr_first_in_ack", g_m[1].w_in_ack, 4'b0001);
    chk("lit_rr_first_rdy", g_m[1].w_rdy, 0);
    @(negedge clk); chk("lit_rr_src0", g_m[1].w_src, 0); chk("lit_rr_tag0", g_m[1].w_tag, 5'd1);
    chk("lit_fp_tag0", g_m[0].w_tag, 5'd1);
    @(negedge clk); chk("lit_rr_src1", g_m[1].w_src, 1); chk("lit_rr_tag1", g_m[1].w_tag, 5'd9);
    chk("lit_fp_tag1", g_m[0].w_tag, 5'd2);
    @(negedge clk); chk("lit_rr_src2", g_m[1].w_src, 2); chk("lit_rr_tag2", g_m[1].w_tag, 5'd17);
    @(negedge clk); chk("lit_rr_src3", g_m[1].w_src, 3); chk("lit_rr_tag3", g_m[1].w_tag, 5'd25);
    @(negedge clk); chk("lit_rr_src4", g_m[1].w_src, 0); chk("lit_rr_tag4", g_m[1].w_tag, 5'd2);
    chk("lit_rr_rdy4", g_m[1].w_rdy, 1);

    // Fixed priority starves channel 3 while channel 1 is ready.
    step(); in_rdy = 4'b1010;
    repeat (3) begin
      @(negedge clk); chk("lit_fp_ch1", g_m[0].w_in_ack, 4'b0010);
    end
    step(); in_rdy = 4'b1000;
    @(negedge clk); chk("lit_fp_ch3", g_m[0].w_in_ack, 4'b1000);

    // Fill the skid buffer with ack low, then drain in order.
    step(); in_rdy = 4'b0000;
    step(); in_rdy = 4'b0001; ack = 1'b0;
    t0 = g_m[0].seq[0];
    @(negedge clk); chk("lit_fill_a", g_m[0].w_in_ack, 4'b0001);
    @(negedge clk); chk("lit_fill_b", g_m[0].w_in_ack, 4'b0001);
    chk("lit_fill_b_tag", g_m[0].w_tag, {2'b00, t0});
    @(negedge clk); chk("lit_full_c", g_m[0].w_in_ack, 4'b0000);
    chk("lit_full_c_rr", g_m[1].w_in_ack, 4'b0000);
    @(negedge clk); chk("lit_full_d", g_m[0].w_in_ack, 4'b0000);
    step(); ack = 1'b1;
    @(negedge clk); chk("lit_drain_e_tag", g_m[0].w_tag, {2'b00, t0});
    chk("lit_drain_e_in_ack", g_m[0].w_in_ack, 4'b0000);
    @(negedge clk); chk("lit_drain_f_tag", g_m[0].w_tag, {2'b00, 3'(t0 + 3'd1)});
    chk("lit_drain_f_in_ack", g_m[0].w_in_ack, 4'b0001);
    @(negedge clk); chk("lit_drain_g_tag", g_m[0].w_tag, {2'b00, 3'(t0 + 3'd2)});

    // Round-robin wrap from ptr=3.
    step(); in_rdy = 4'b1000;
    @(negedge clk); chk("lit_rr_ptr3", g_m[1].w_in_ack, 4'b1000);
    step(); in_rdy = 4'b1001;
    @(negedge clk); chk("lit_rr_wrap0", g_m[1].w_in_ack, 4'b0001);
    @(negedge clk); chk("lit_rr_then3", g_m[1].w_in_ack, 4'b1000);

    // Reset mid-stream with both buffers full.
    step(); in_rdy = 4'b1111; ack = 1'b0;
    repeat (2) step();
    #2 rst = 1'b0;
    #1;
    chk("lit_async_rr_rdy", g_m[1].w_rdy, 0);
    chk("lit_async_fp_rdy", g_m[0].w_rdy, 0);
    chk("lit_async_rr_in_ack", g_m[1].w_in_ack, 0);
    chk("lit_async_fp_in_ack", g_m[0].w_in_ack, 0);
    step();
    step(); rst = 1'b1; ack = 1'b1;
    @(negedge clk); chk("lit_post_rr_in_ack", g_m[1].w_in_ack, 4'b0001);
    @(negedge clk); chk("lit_post_rr_src", g_m[1].w_src, 0);
    chk("lit_post_rr_rdy", g_m[1].w_rdy, 1);

    // Mixed ready/ack patterns checked by the reference models.
    for (int v = 0; v < 12; v++) begin
      step();
      in_rdy = vec[v][4:1];
      ack    = vec[v][0];
    end
    step(); in_rdy = 4'b0000; ack = 1'b1;
    repeat (3) step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
